pwm_system_pwm_out: RTL and testbench

Avalon-MM slave PWM generator for the PWM system: the write/output counterpart of the system's read-only input PIO slaves. Software writes period, duty and control registers over the same 2-bit-address, 32-bit-data slave interface; the block drives a registered PWM output plus a period-wrap interrupt. New period/duty values are double-buffered and take effect only at a period boundary, so the waveform never glitches.

---
 rtl/pwm_system_pwm_out.sv | 121 ++++++++++++
 tb/tb_pwm_system_pwm_out.sv | 312 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/pwm_system_pwm_out.sv
// PWM generator behind an Avalon-MM slave with 2-bit address and 32-bit data.
// PERIOD and DUTY are double-buffered. Software writes land in pending
// registers, and the counter adopts them only at a period boundary, or
// continuously while the generator is disabled. This keeps the output free
// of glitches.
module pwm_system_pwm_out #(
  parameter int CNT_W = 16
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic [1:0]  address,
  input  logic        chipselect,
  input  logic        write_n,
  input  logic [31:0] writedata,
  output logic [31:0] readdata,
  output logic        pwm_out,
  output logic        irq
);

  localparam logic [1:0] ADDR_CTRL   = 2'd0;
  localparam logic [1:0] ADDR_PERIOD = 2'd1;
  localparam logic [1:0] ADDR_DUTY   = 2'd2;
  localparam logic [1:0] ADDR_STATUS = 2'd3;

  logic             en_reg;
  logic             inv_reg;
  logic             ie_reg;
  logic [CNT_W-1:0] period_pend_reg;
  logic [CNT_W-1:0] duty_pend_reg;
  logic [CNT_W-1:0] period_act_reg;
  logic [CNT_W-1:0] duty_act_reg;
  logic [CNT_W-1:0] cnt_reg;
  logic             wrap_reg;

  logic             wr;
  logic             at_end;
  logic             raw;
  logic [31:0]      rd_mux;

  assign wr     = chipselect & ~write_n;
  assign at_end = en_reg & (cnt_reg == period_act_reg);
  assign raw    = en_reg & (cnt_reg < duty_act_reg);

  // Read mux. Undefined bits read as zero.
  always_comb begin
    rd_mux = '0;
    case (address)
      ADDR_CTRL:   rd_mux[2:0] = {ie_reg, inv_reg, en_reg};
      ADDR_PERIOD: rd_mux[CNT_W-1:0] = period_pend_reg;
      ADDR_DUTY:   rd_mux[CNT_W-1:0] = duty_pend_reg;
      default: begin
        rd_mux[31]        = wrap_reg;
        rd_mux[CNT_W-1:0] = cnt_reg;
      end
    endcase
  end

  // Software-visible control and pending registers.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      en_reg          <= 1'b0;
      inv_reg         <= 1'b0;
      ie_reg          <= 1'b0;
      period_pend_reg <= '0;
      duty_pend_reg   <= '0;
    end else if (wr) begin
      case (address)
        ADDR_CTRL: begin
          en_reg  <= writedata[0];
          inv_reg <= writedata[1];
          ie_reg  <= writedata[2];
        end
        ADDR_PERIOD: period_pend_reg <= writedata[CNT_W-1:0];
        ADDR_DUTY:   duty_pend_reg   <= writedata[CNT_W-1:0];
        default: ;
      endcase
    end
  end

  // Counter and active values. Pending values are adopted while idle or at
  // the wrap. A write in the same cycle as the wrap is picked up at the next
  // wrap, because this block sees the pre-write pending value.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      cnt_reg        <= '0;
      period_act_reg <= '0;
      duty_act_reg   <= '0;
    end else if (!en_reg || at_end) begin
      cnt_reg        <= '0;
      period_act_reg <= period_pend_reg;
      duty_act_reg   <= duty_pend_reg;
    end else begin
      cnt_reg <= cnt_reg + 1'b1;
    end
  end

  // WRAP flag. A wrap in the same cycle as a STATUS write clear keeps the flag set.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      wrap_reg <= 1'b0;
    end else if (at_end) begin
      wrap_reg <= 1'b1;
    end else if (wr && (address == ADDR_STATUS)) begin
      wrap_reg <= 1'b0;
    end
  end

  // Registered outputs: waveform, interrupt and read data.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      pwm_out  <= 1'b0;
      irq      <= 1'b0;
      readdata <= '0;
    end else begin
      pwm_out  <= raw ^ inv_reg;
      irq      <= wrap_reg & ie_reg;
      readdata <= rd_mux;
    end
  end

endmodule

// File: tb/tb_pwm_system_pwm_out.sv
// Bench for pwm_system_pwm_out. It runs directed scenarios that check
// closed-form waveform patterns, plus randomized bus traffic. Outputs are
// compared against a behavioural model of the register map.
module tb_pwm_system_pwm_out;

  localparam int CNT_W = 16;
  localparam int unsigned MASK = (1 << CNT_W) - 1;

  logic        clk;
  logic        reset_n;
  logic [1:0]  address;
  logic        chipselect;
  logic        write_n;
  logic [31:0] writedata;
  logic [31:0] readdata;
  logic        pwm_out;
  logic        irq;

  int total;
  int bad;

  // behavioural model state
  bit          m_en, m_inv, m_ie, m_wrap, m_pwm, m_irq;
  int unsigned m_pp, m_pd, m_pa, m_da, m_cnt;
  logic [31:0] m_rd;

  pwm_system_pwm_out #(.CNT_W(CNT_W)) dut (
    .clk        (clk),
    .reset_n    (reset_n),
    .address    (address),
    .chipselect (chipselect),
    .write_n    (write_n),
    .writedata  (writedata),
    .readdata   (readdata),
    .pwm_out    (pwm_out),
    .irq        (irq)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [31:0] model_read(input logic [1:0] a);
    logic [31:0] r;
    r = '0;
    case (a)
      2'd0: r = {29'd0, m_ie, m_inv, m_en};
      2'd1: r = m_pp;
      2'd2: r = m_pd;
      default: begin
        r     = m_cnt;
        r[31] = m_wrap;
      end
    endcase
    return r;
  endfunction

  // Advance the model by one clock using the inputs present at the edge.
  task automatic model_step();
    bit          wr, last, n_pwm, n_irq;
    logic [31:0] n_rd;
    if (!reset_n) begin
      m_en = 0; m_inv = 0; m_ie = 0; m_wrap = 0; m_pwm = 0; m_irq = 0;
      m_pp = 0; m_pd = 0; m_pa = 0; m_da = 0; m_cnt = 0; m_rd = '0;
      return;
    end
    wr    = chipselect && !write_n;
    n_rd  = model_read(address);
    n_pwm = (m_en && (m_cnt < m_da)) ^ m_inv;
    n_irq = m_wrap && m_ie;
    last  = m_en && (m_cnt == m_pa);
    if (!m_en || last) begin
      m_cnt = 0;
      m_pa  = m_pp;
      m_da  = m_pd;
    end else begin
      m_cnt = m_cnt + 1;
    end
    if (last) m_wrap = 1;
    else if (wr && address == 2'd3) m_wrap = 0;
    if (wr) begin
      case (address)
        2'd0: begin m_en = writedata[0]; m_inv = writedata[1]; m_ie = writedata[2]; end
        2'd1: m_pp = writedata & MASK;
        2'd2: m_pd = writedata & MASK;
        default: ;
      endcase
    end
    m_pwm = n_pwm;
    m_irq = n_irq;
    m_rd  = n_rd;
  endtask

  task automatic cycle();
    @(posedge clk);
    model_step();
    #1;
  endtask

  task automatic write_reg(input logic [1:0] a, input logic [31:0] d);
    address    = a;
    writedata  = d;
    chipselect = 1'b1;
    write_n    = 1'b0;
    cycle();
    chipselect = 1'b0;
    write_n    = 1'b1;
  endtask

  task automatic test_reset();
    reset_n = 1'b0; address = 2'd0; chipselect = 1'b0; write_n = 1'b1; writedata = '0;
    cycle(); cycle();
    reset_n = 1'b1;
    write_reg(2'd1, 32'd3);
    write_reg(2'd2, 32'd2);
    write_reg(2'd0, 32'd7);
    repeat (5) cycle();
    address = 2'd3;
    reset_n = 1'b0;
    cycle(); cycle();
    total++; if (pwm_out !== 1'b0) begin bad++; $display("FAIL reset_pwm got=%b want=0", pwm_out); end
    total++; if (irq !== 1'b0) begin bad++; $display("FAIL reset_irq got=%b want=0", irq); end
    total++; if (readdata !== 32'd0) begin bad++; $display("FAIL reset_readdata got=%h want=0", readdata); end
    reset_n = 1'b1;
    cycle();
    total++; if (readdata !== 32'd0) begin bad++; $display("FAIL reset_status got=%h want=0", readdata); end
    address = 2'd0;
    cycle();
    total++; if (readdata !== 32'd0) begin bad++; $display("FAIL reset_ctrl got=%h want=0", readdata); end
    $display("test_reset done");
  endtask

  task automatic test_basic();
    bit exp;
    write_reg(2'd1, 32'd9);
    write_reg(2'd2, 32'd3);
    write_reg(2'd0, 32'd1);
    for (int k = 1; k <= 20; k++) begin
      cycle();
      exp = ((k - 1) % 10) < 3;
      total++; if (pwm_out !== exp) begin bad++; $display("FAIL basic_pwm k=%0d got=%b want=%b", k, pwm_out, exp); end
      total++; if (pwm_out !== m_pwm) begin bad++; $display("FAIL basic_model k=%0d got=%b want=%b", k, pwm_out, m_pwm); end
    end
    $display("test_basic done");
  endtask

  task automatic test_glitch_free();
    bit exp;
    int guard = 0;
    while (m_cnt != 5 && guard < 30) begin cycle(); guard++; end
    total++; if (m_cnt != 5) begin bad++; $display("FAIL glitch_sync got=%0d want=5", m_cnt); end
    write_reg(2'd2, 32'd7);
    total++; if (pwm_out !== 1'b0) begin bad++; $display("FAIL glitch_wr_edge got=%b want=0", pwm_out); end
    // cnt 6..9 low under old duty, then new period: 7 high, 3 low
    for (int k = 0; k < 14; k++) begin
      cycle();
      exp = (k >= 4) && (k < 11);
      total++; if (pwm_out !== exp) begin bad++; $display("FAIL glitch_pwm k=%0d got=%b want=%b", k, pwm_out, exp); end
    end
    $display("test_glitch_free done");
  endtask

  task automatic test_extremes();
    bit exp;
    write_reg(2'd2, 32'd0);
    repeat (12) cycle();
    for (int k = 0; k < 12; k++) begin
      cycle();
      total++; if (pwm_out !== 1'b0) begin bad++; $display("FAIL duty0 k=%0d got=%b want=0", k, pwm_out); end
    end
    write_reg(2'd2, 32'd12);
    repeat (12) cycle();
    for (int k = 0; k < 12; k++) begin
      cycle();
      total++; if (pwm_out !== 1'b1) begin bad++; $display("FAIL duty_gt_period k=%0d got=%b want=1", k, pwm_out); end
    end
    write_reg(2'd1, 32'd0);
    write_reg(2'd2, 32'd1);
    repeat (12) cycle();
    for (int k = 0; k < 8; k++) begin
      cycle();
      total++; if (pwm_out !== 1'b1) begin bad++; $display("FAIL period0 k=%0d got=%b want=1", k, pwm_out); end
    end
    write_reg(2'd3, 32'd0);
    cycle();
    total++; if (readdata[31] !== 1'b1) begin bad++; $display("FAIL period0_wrap got=%b want=1", readdata[31]); end
    write_reg(2'd0, 32'd0);
    write_reg(2'd1, 32'd9);
    write_reg(2'd2, 32'd3);
    write_reg(2'd0, 32'd3);
    for (int k = 1; k <= 20; k++) begin
      cycle();
      exp = ((k - 1) % 10) >= 3;
      total++; if (pwm_out !== exp) begin bad++; $display("FAIL inv_pwm k=%0d got=%b want=%b", k, pwm_out, exp); end
    end
    $display("test_extremes done");
  endtask

  task automatic test_irq();
    int guard = 0;
    write_reg(2'd0, 32'd0);
    write_reg(2'd3, 32'd0);
    write_reg(2'd1, 32'd4);
    write_reg(2'd2, 32'd2);
    write_reg(2'd0, 32'd5);
    for (int k = 1; k <= 5; k++) begin
      cycle();
      total++; if (irq !== 1'b0) begin bad++; $display("FAIL irq_early k=%0d got=%b want=0", k, irq); end
    end
    cycle();
    total++; if (irq !== 1'b1) begin bad++; $display("FAIL irq_rise got=%b want=1", irq); end
    write_reg(2'd3, 32'd0);
    total++; if (irq !== 1'b1) begin bad++; $display("FAIL irq_clr_edge got=%b want=1", irq); end
    cycle();
    total++; if (irq !== 1'b0) begin bad++; $display("FAIL irq_cleared got=%b want=0", irq); end
    while (m_cnt != 4 && guard < 20) begin cycle(); guard++; end
    total++; if (m_cnt != 4) begin bad++; $display("FAIL irq_sync got=%0d want=4", m_cnt); end
    write_reg(2'd3, 32'd0);
    cycle();
    total++; if (readdata[31] !== 1'b1) begin bad++; $display("FAIL irq_collide_wrap got=%b want=1", readdata[31]); end
    total++; if (irq !== 1'b1) begin bad++; $display("FAIL irq_collide_irq got=%b want=1", irq); end
    $display("test_irq done");
  endtask

  task automatic test_disable_readback();
    int guard = 0;
    int unsigned p, d;
    write_reg(2'd0, 32'd0);
    write_reg(2'd1, 32'd9);
    write_reg(2'd2, 32'd3);
    write_reg(2'd0, 32'd1);
    while (m_cnt != 6 && guard < 30) begin cycle(); guard++; end
    total++; if (m_cnt != 6) begin bad++; $display("FAIL dis_sync got=%0d want=6", m_cnt); end
    write_reg(2'd0, 32'd2);
    total++; if (pwm_out !== 1'b0) begin bad++; $display("FAIL dis_edge got=%b want=0", pwm_out); end
    address = 2'd3;
    cycle();
    total++; if (pwm_out !== 1'b1) begin bad++; $display("FAIL dis_inv got=%b want=1", pwm_out); end
    cycle();
    total++; if (readdata[CNT_W-1:0] !== '0) begin bad++; $display("FAIL dis_cnt got=%0d want=0", readdata[CNT_W-1:0]); end
    p = $urandom_range(0, MASK);
    d = $urandom_range(0, MASK);
    write_reg(2'd0, 32'd4);
    write_reg(2'd1, p);
    write_reg(2'd2, d);
    for (int a = 0; a < 4; a++) begin
      address = 2'(a);
      cycle();
      total++; if (readdata !== m_rd) begin bad++; $display("FAIL readback a=%0d got=%h want=%h", a, readdata, m_rd); end
    end
    address = 2'd1;
    cycle();
    total++; if (readdata !== p) begin bad++; $display("FAIL readback_period got=%h want=%h", readdata, p); end
    address = 2'd2;
    cycle();
    total++; if (readdata !== d) begin bad++; $display("FAIL readback_duty got=%h want=%h", readdata, d); end
    address = 2'd0;
    cycle();
    total++; if (readdata !== 32'd4) begin bad++; $display("FAIL readback_ctrl got=%h want=4", readdata); end
    $display("test_disable_readback done");
  endtask

  task automatic test_random_pattern();
    int unsigned p, d;
    bit exp;
    for (int it = 0; it < 4; it++) begin
      p = $urandom_range(1, 12);
      d = $urandom_range(0, p + 2);
      write_reg(2'd0, 32'd0);
      write_reg(2'd1, p);
      write_reg(2'd2, d);
      write_reg(2'd0, 32'd1);
      for (int k = 1; k <= 2 * (p + 1); k++) begin
        cycle();
        exp = ((k - 1) % (p + 1)) < d;
        total++; if (pwm_out !== exp) begin bad++; $display("FAIL rand_pattern p=%0d d=%0d k=%0d got=%b want=%b", p, d, k, pwm_out, exp); end
      end
      $display("pattern p=%0d d=%0d checked", p, d);
    end
  endtask

  task automatic test_random_bus();
    for (int k = 0; k < 400; k++) begin
      reset_n    = ($urandom_range(0, 99) != 0);
      chipselect = 1'($urandom_range(0, 1));
      write_n    = ($urandom_range(0, 2) == 0) ? 1'b0 : 1'b1;
      address    = 2'($urandom_range(0, 3));
      writedata  = (address == 2'd1 || address == 2'd2) ? 32'($urandom_range(0, 12)) : $urandom;
      cycle();
      total++; if (pwm_out !== m_pwm) begin bad++; $display("FAIL rand_pwm k=%0d got=%b want=%b", k, pwm_out, m_pwm); end
      total++; if (irq !== m_irq) begin bad++; $display("FAIL rand_irq k=%0d got=%b want=%b", k, irq, m_irq); end
      total++; if (readdata !== m_rd) begin bad++; $display("FAIL rand_rd k=%0d got=%h want=%h", k, readdata, m_rd); end
    end
    reset_n = 1'b1; chipselect = 1'b0; write_n = 1'b1;
    $display("test_random_bus done");
  endtask

  initial begin
    total = 0;
    bad   = 0;
    test_reset();
    test_basic();
    test_glitch_free();
    test_extremes();
    test_irq();
    test_disable_readback();
    test_random_pattern();
    test_random_bus();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
